// File: rtl/t04_lcd_write_engine.sv
// 8080-style write engine for ILI9341-class panels: raw CMD (0-4 params) or windowed RGB565 FILL.
// Optional post-command DELAY state is built only when T04_LCD_DELAY_EN is defined.
module t04_lcd_write_engine #(
   parameter int WR_LOW  = 1,
   parameter int WR_HIGH = 1,
   parameter int CNT_W   = 17,
   parameter int DLY_W   = 23
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       op,
   input  logic [7:0]       cmd,
   input  logic [31:0]      params,
   input  logic [2:0]       nparams,
   input  logic [DLY_W-1:0] delay,
   input  logic [31:0]      x_win,
   input  logic [31:0]      y_win,
   input  logic [15:0]      color,
   input  logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             csx,
   output logic             dcx,
   output logic             wrx,
   output logic [7:0]       data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_LOW   = 3'd2;
   localparam logic [2:0] S_HIGH  = 3'd3;
   localparam logic [2:0] S_END   = 3'd4;
`ifdef T04_LCD_DELAY_EN
   localparam logic [2:0] S_DELAY = 3'd5;
`endif
   localparam logic [1:0] OP_CMD  = 2'b00;

   localparam int PH_MAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(WR_LOW - 1);
   localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(WR_HIGH - 1);

   logic [2:0]       state_q, state_d;
   logic [PH_W-1:0]  ph_q, ph_d;
   logic [3:0]       idx_q, idx_d;
   logic             lo_q, lo_d;
   logic [CNT_W-1:0] pix_q, pix_d;
   logic [1:0]       op_q, op_d;
   logic [31:0]      par_q, par_d;
   logic [2:0]       np_q, np_d;
   logic [31:0]      xw_q, xw_d;
   logic [31:0]      yw_q, yw_d;
   logic [15:0]      col_q, col_d;
   logic             alive_q;
   logic             csx_q, csx_d, dcx_q, dcx_d, wrx_q, wrx_d;
   logic [7:0]       data_q, data_d;
`ifdef T04_LCD_DELAY_EN
   logic [DLY_W-1:0] dly_q, dly_d;
`else
   logic             unused_delay;
   assign unused_delay = ^delay;
`endif

   logic [2:0]       np_c;
   logic [3:0]       nxt_idx;
   logic             nxt_lo, nxt_dcx, last;
   logic [7:0]       nxt_dat;
   logic [CNT_W-1:0] nxt_pix;

   assign np_c      = (nparams > 3'd4) ? 3'd4 : nparams;
   assign req_ready = alive_q && (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_END);
   assign csx       = csx_q;
   assign dcx       = dcx_q;
   assign wrx       = wrx_q;
   assign data      = data_q;

   // Position after the byte currently on the bus; FILL idx 11 marks the pixel phase.
   always_comb begin
      nxt_idx = idx_q + 4'd1;
      nxt_lo  = 1'b0;
      nxt_pix = pix_q;
      nxt_dat = 8'h00;
      nxt_dcx = 1'b1;
      last    = 1'b0;
      if (op_q == OP_CMD) begin
         last = (idx_q == {1'b0, np_q});
         case (idx_q)
            4'd0:    nxt_dat = par_q[31:24];
            4'd1:    nxt_dat = par_q[23:16];
            4'd2:    nxt_dat = par_q[15:8];
            default: nxt_dat = par_q[7:0];
         endcase
      end else if (idx_q < 4'd11) begin
         last = (idx_q == 4'd10) && (pix_q == '0);
         case (nxt_idx)
            4'd1:    nxt_dat = xw_q[31:24];
            4'd2:    nxt_dat = xw_q[23:16];
            4'd3:    nxt_dat = xw_q[15:8];
            4'd4:    nxt_dat = xw_q[7:0];
            4'd5:    begin nxt_dat = 8'h2B; nxt_dcx = 1'b0; end
            4'd6:    nxt_dat = yw_q[31:24];
            4'd7:    nxt_dat = yw_q[23:16];
            4'd8:    nxt_dat = yw_q[15:8];
            4'd9:    nxt_dat = yw_q[7:0];
            4'd10:   begin nxt_dat = 8'h2C; nxt_dcx = 1'b0; end
            default: nxt_dat = col_q[15:8];
         endcase
      end else begin
         nxt_idx = idx_q;
         if (lo_q) begin
            last    = (pix_q == CNT_W'(1));
            nxt_pix = pix_q - CNT_W'(1);
            nxt_dat = col_q[15:8];
         end else begin
            nxt_lo  = 1'b1;
            nxt_dat = col_q[7:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      idx_d   = idx_q;
      lo_d    = lo_q;
      pix_d   = pix_q;
      op_d    = op_q;
      par_d   = par_q;
      np_d    = np_q;
      xw_d    = xw_q;
      yw_d    = yw_q;
      col_d   = col_q;
      csx_d   = csx_q;
      dcx_d   = dcx_q;
      wrx_d   = wrx_q;
      data_d  = data_q;
`ifdef T04_LCD_DELAY_EN
      dly_d   = dly_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               op_d  = op;
               par_d = params;
               np_d  = np_c;
               xw_d  = x_win;
               yw_d  = y_win;
               col_d = color;
               pix_d = count;
               idx_d = 4'd0;
               lo_d  = 1'b0;
               ph_d  = '0;
`ifdef T04_LCD_DELAY_EN
               dly_d = delay;
`endif
               if (op[1]) begin
                  state_d = S_END;
               end else begin
                  state_d = S_SETUP;
                  csx_d   = 1'b0;
                  wrx_d   = 1'b1;
                  dcx_d   = 1'b0;
                  data_d  = (op == OP_CMD) ? cmd : 8'h2A;
               end
            end
         end
         S_SETUP: begin
            state_d = S_LOW;
            wrx_d   = 1'b0;
            ph_d    = '0;
         end
         S_LOW: begin
            if (ph_q == LOW_LAST) begin
               state_d = S_HIGH;
               wrx_d   = 1'b1;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         S_HIGH: begin
            if (ph_q == HIGH_LAST) begin
               ph_d  = '0;
               pix_d = nxt_pix;
               if (!last) begin
                  state_d = S_LOW;
                  wrx_d   = 1'b0;
                  data_d  = nxt_dat;
                  dcx_d   = nxt_dcx;
                  idx_d   = nxt_idx;
                  lo_d    = nxt_lo;
               end else begin
                  csx_d = 1'b1;
`ifdef T04_LCD_DELAY_EN
                  state_d = ((op_q == OP_CMD) && (dly_q != '0)) ? S_DELAY : S_END;
`else
                  state_d = S_END;
`endif
               end
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
`ifdef T04_LCD_DELAY_EN
         S_DELAY: begin
            dly_d = dly_q - DLY_W'(1);
            if (dly_q == DLY_W'(1)) state_d = S_END;
         end
`endif
         S_END:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         ph_q    <= '0;
         idx_q   <= 4'd0;
         lo_q    <= 1'b0;
         pix_q   <= '0;
         op_q    <= 2'b00;
         par_q   <= 32'h0;
         np_q    <= 3'd0;
         xw_q    <= 32'h0;
         yw_q    <= 32'h0;
         col_q   <= 16'h0;
         alive_q <= 1'b0;
         csx_q   <= 1'b1;
         dcx_q   <= 1'b1;
         wrx_q   <= 1'b1;
         data_q  <= 8'h00;
`ifdef T04_LCD_DELAY_EN
         dly_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         pix_q   <= pix_d;
         op_q    <= op_d;
         par_q   <= par_d;
         np_q    <= np_d;
         xw_q    <= xw_d;
         yw_q    <= yw_d;
         col_q   <= col_d;
         alive_q <= 1'b1;
         csx_q   <= csx_d;
         dcx_q   <= dcx_d;
         wrx_q   <= wrx_d;
         data_q  <= data_d;
`ifdef T04_LCD_DELAY_EN
         dly_q   <= dly_d;
`endif
      end
   end

endmodule

// File: tb/tb_t04_lcd_write_engine.sv
// Bench for t04_lcd_write_engine: directed + random requests against a byte-list/latency model.
// Honours T04_LCD_DELAY_EN when computing expected CMD latency.
module tb_t04_lcd_write_engine;
   localparam int TL = 2;
   localparam int TH = 1;
   localparam int CW = 17;
   localparam int DW = 23;

   logic          clk = 1'b0;
   logic          nrst;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    op;
   logic [7:0]    cmd;
   logic [31:0]   params;
   logic [2:0]    nparams;
   logic [DW-1:0] delay;
   logic [31:0]   x_win;
   logic [31:0]   y_win;
   logic [15:0]   color;
   logic [CW-1:0] count;
   logic          busy, done, csx, dcx, wrx;
   logic [7:0]    data;

   t04_lcd_write_engine #(.WR_LOW(TL), .WR_HIGH(TH), .CNT_W(CW), .DLY_W(DW)) dut (
      .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
      .op(op), .cmd(cmd), .params(params), .nparams(nparams), .delay(delay),
      .x_win(x_win), .y_win(y_win), .color(color), .count(count),
      .busy(busy), .done(done), .csx(csx), .dcx(dcx), .wrx(wrx), .data(data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Bus observer: samples on the falling edge, away from the active edge.
   int         nedge = 0;
   int         acc_q[$];
   int         done_q[$];
   logic [8:0] byte_q[$];
   logic       prev_wrx = 1'b1;
   logic [8:0] low_dat = 9'h0;
   int         glitch = 0, csx_bad = 0, busy_err = 0, rdy_err = 0, csx_lows = 0;
   int         hi_run = 0, min_gap = 1000;
   bit         seen_low = 0, in_txn = 0, pend = 0;

   always @(negedge clk) begin
      nedge++;
      if (!nrst) begin
         prev_wrx = 1'b1; in_txn = 0; pend = 0; seen_low = 0; hi_run = 0;
      end else begin
         if (pend) begin in_txn = 1; pend = 0; end
         if (busy !== in_txn) busy_err++;
         if (req_ready !== !in_txn) rdy_err++;
         if (done === 1'b1) begin done_q.push_back(nedge); in_txn = 0; end
         if (req_valid && req_ready) begin acc_q.push_back(nedge); pend = 1; end
         if (!wrx && prev_wrx) low_dat = {dcx, data};
         if (!wrx && ({dcx, data} !== low_dat)) glitch++;
         if (!wrx && csx) csx_bad++;
         if (wrx && !prev_wrx) byte_q.push_back({dcx, data});
         prev_wrx = wrx;
         if (csx) hi_run++;
         else begin
            csx_lows++;
            if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
            seen_low = 1; hi_run = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic set_fields(input logic [1:0] o, input logic [7:0] c, input logic [31:0] p,
                             input logic [2:0] np, input logic [DW-1:0] d, input logic [31:0] xw,
                             input logic [31:0] yw, input logic [15:0] col, input logic [CW-1:0] cnt);
      op = o; cmd = c; params = p; nparams = np; delay = d;
      x_win = xw; y_win = yw; color = col; count = cnt;
   endtask

   task automatic scramble();
      set_fields(2'($urandom), 8'($urandom), $urandom, 3'($urandom), DW'($urandom), $urandom,
                 $urandom, 16'($urandom), CW'($urandom));
   endtask

   // Model: byte list straight from the request rules, latency = 2 + B*(TL+TH) + D.
   task automatic run_req(input string tag, input logic [1:0] o, input logic [7:0] c,
                          input logic [31:0] p, input logic [2:0] np, input logic [DW-1:0] d,
                          input logic [31:0] xw, input logic [31:0] yw, input logic [15:0] col,
                          input logic [CW-1:0] cnt, input int abort_at);
      logic [8:0] exp_q[$];
      int n, lat, t, dly_eff;
      exp_q = {};
      if (o == 2'b00) begin
         exp_q.push_back({1'b0, c});
         n = (np > 3'd4) ? 4 : int'(np);
         for (int k = 0; k < n; k++) exp_q.push_back({1'b1, p[31-8*k -: 8]});
      end else if (o == 2'b01) begin
         exp_q.push_back({1'b0, 8'h2A});
         for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, xw[31-8*k -: 8]});
         exp_q.push_back({1'b0, 8'h2B});
         for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, yw[31-8*k -: 8]});
         exp_q.push_back({1'b0, 8'h2C});
         for (int k = 0; k < int'(cnt); k++) begin
            exp_q.push_back({1'b1, col[15:8]});
            exp_q.push_back({1'b1, col[7:0]});
         end
      end
`ifdef T04_LCD_DELAY_EN
      dly_eff = int'(d);
`else
      dly_eff = 0;
`endif
      if (o[1]) lat = 1;
      else lat = 2 + exp_q.size() * (TL + TH) + ((o == 2'b00) ? dly_eff : 0);

      acc_q.delete(); done_q.delete(); byte_q.delete(); csx_lows = 0;
      set_fields(o, c, p, np, d, xw, yw, col, cnt);
      req_valid = 1'b1;
      t = 0;
      while (acc_q.size() == 0 && t < 20) begin @(posedge clk); #1; t++; end
      chk({tag, " accept"}, acc_q.size(), 1);
      scramble();  // keep req_valid high with junk while busy
      if (abort_at > 0) begin
         repeat (abort_at) begin @(posedge clk); #1; end
         req_valid = 1'b0;
         return;
      end
      t = 0;
      while (done_q.size() == 0 && t < lat + 20) begin @(posedge clk); #1; t++; end
      req_valid = 1'b0;
      chk({tag, " done_seen"}, done_q.size(), 1);
      chk({tag, " not_queued"}, acc_q.size(), 1);
      if (done_q.size() > 0 && acc_q.size() > 0)
         chk({tag, " latency"}, done_q[0] - acc_q[0], lat);
      chk({tag, " nbytes"}, byte_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++)
         chk($sformatf("%s byte%0d", tag, i), byte_q[i], exp_q[i]);
      if (o[1]) chk({tag, " csx_idle"}, csx_lows, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b1;
      req_valid = 1'b0;
      set_fields(2'b00, 8'h00, 32'h0, 3'd0, '0, 32'h0, 32'h0, 16'h0, '0);
      #2 nrst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst csx", csx, 1);
      chk("rst wrx", wrx, 1);
      chk("rst dcx", dcx, 1);
      chk("rst data", data, 0);
      chk("rst done", done, 0);
      chk("rst busy", busy, 0);
      @(negedge clk); #1 nrst = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_release", req_ready, 1);

      run_req("cmd3a", 2'b00, 8'h3A, 32'h55000000, 3'd1, '0, 0, 0, 0, '0, 0);
      run_req("cmd11_dly", 2'b00, 8'h11, 32'h0, 3'd0, DW'(100), 0, 0, 0, '0, 0);
      run_req("fill10", 2'b01, 8'h00, 32'h0, 3'd0, DW'(7), 32'h000A0013, 32'h00050005,
              16'hF800, CW'(10), 0);
      run_req("fill0", 2'b01, 8'h00, 32'h0, 3'd0, '0, 32'h12345678, 32'h9ABCDEF0,
              16'h07E0, CW'(0), 0);
      run_req("np7", 2'b00, 8'h2C, 32'hA1B2C3D4, 3'd7, '0, 0, 0, 0, '0, 0);
      run_req("np4", 2'b00, 8'h36, 32'h11223344, 3'd4, DW'(3), 0, 0, 0, '0, 0);
      run_req("rsv11", 2'b11, 8'h29, 32'hFFFFFFFF, 3'd4, DW'(5), 0, 0, 0, CW'(3), 0);
      run_req("rsv10", 2'b10, 8'h29, 32'h0, 3'd0, '0, 0, 0, 0, CW'(2), 0);

      for (int it = 0; it < 30; it++)
         run_req($sformatf("rnd%0d", it), 2'($urandom_range(0, 3)), 8'($urandom), $urandom,
                 3'($urandom), DW'($urandom_range(0, 12)), $urandom, $urandom, 16'($urandom),
                 CW'($urandom_range(0, 4)), 0);

      // Reset in the middle of the pixel bytes of a FILL.
      run_req("fill_abort", 2'b01, 8'h00, 32'h0, 3'd0, '0, 32'h00000010, 32'h00000010,
              16'hF8F8, CW'(10), 45);
      #2 nrst = 1'b0;
      #1;
      chk("rst_mid csx", csx, 1);
      chk("rst_mid wrx", wrx, 1);
      chk("rst_mid dcx", dcx, 1);
      chk("rst_mid data", data, 0);
      chk("rst_mid busy", busy, 0);
      chk("rst_mid done", done, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1 nrst = 1'b1;
      @(posedge clk); #1;
      run_req("cmd29", 2'b00, 8'h29, 32'h0, 3'd0, '0, 0, 0, 0, '0, 0);

      chk("busy_track", busy_err, 0);
      chk("ready_track", rdy_err, 0);
      chk("data_stable_low", glitch, 0);
      chk("strobe_csx_low", csx_bad, 0);
      chk("csx_gap_ge2", (min_gap >= 2), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/t04_lcd_write_engine.md
# t04_lcd_write_engine

Parametrised 8080-style parallel write engine for the ILI9341-class TFT on the team's display path. It supersedes fixed per-colour command sequences with a generic request interface: a raw command with 0–4 parameter bytes and an optional post-command delay, or a windowed fill of N pixels of one RGB565 colour. It sits between the screen controller FSM and the LCD pins and drives `csx`, `dcx`, `wrx` and `data` with programmable write-strobe timing.

## Interface
- `WR_LOW`, 1: cycles `wrx` is held low per byte (≥1).
- `WR_HIGH`, 1: cycles `wrx` is held high per byte (≥1).
- `CNT_W`, 17: width of pixel `count`.
- `DLY_W`, 23: width of `delay`.

- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: engine idle; a request is accepted on a rising edge with `req_valid && req_ready`.
- `op` in 2: 00 CMD, 01 FILL, 10/11 reserved.
- `cmd` in 8: command byte (CMD).
- `params` in 32: parameter bytes, sent MSB byte first (CMD).
- `nparams` in 3: parameter count; values above 4 are clamped to 4.
- `delay` in DLY_W: post-command wait in cycles (CMD).
- `x_win` in 32: {xs[15:0], xe[15:0]} (FILL).
- `y_win` in 32: {ys[15:0], ye[15:0]} (FILL).
- `color` in 16: RGB565 (FILL).
- `count` in CNT_W: pixels to write (FILL).
- `busy` out 1: high from acceptance until `done`, inclusive.
- `done` out 1: single-cycle completion pulse.
- `csx`, `dcx`, `wrx` out 1: LCD strobes, registered.
- `data` out 8: LCD data bus, registered.

## Operation
- All request fields are captured into internal registers at acceptance. Input changes after acceptance are ignored.
- States:
  - IDLE: `req_ready`=1.
  - SETUP: one cycle; `csx`=0, `wrx`=1, first byte and its `dcx` are driven.
  - LOW: `WR_LOW` cycles with `wrx`=0.
  - HIGH: `WR_HIGH` cycles with `wrx`=1.
  - DELAY
  - END: one cycle; `done`=1.
- Transitions:
  - HIGH → LOW for the next byte. `data` and `dcx` update on the same edge that drops `wrx`.
  - After the final byte's HIGH phase → DELAY if the op is CMD and `delay`≠0, otherwise → END.
  - `csx` returns to 1 on entry to DELAY or END.
  - DELAY counts `delay` cycles, then → END.
  - END → IDLE.
- CMD byte list: `cmd` with `dcx`=0, then `nparams` bytes of `params[31:24]`, `[23:16]`, … with `dcx`=1.
- FILL byte list, 11 + 2·count bytes:
  - 0x2A (`dcx`=0), then `x_win` bytes MSB first (`dcx`=1).
  - 0x2B, then `y_win` bytes.
  - 0x2C.
  - `count` repetitions of {`color[15:8]`, `color[7:0]`} with `dcx`=1.
  - `count`=0 sends window and RAMWR only.
  - Pixel counter is CNT_W wide and counts down to zero; no wrap.
- Reserved op: accepted, no bus activity, SETUP skipped, `csx` stays 1, goes straight to END.
- Reset (any time, including mid-transfer): `csx`=`wrx`=`dcx`=1, `data`=0, `done`=0, `busy`=0, state IDLE. `req_ready`=1 from the first edge after release.

## Timing
- Each byte occupies WR_LOW + WR_HIGH cycles. LCD latches on the `wrx` rising edge. `data` is stable for the whole low phase.
- Latency, with acceptance at edge E:
  - SETUP in cycle E+1.
  - `done` in cycle E+2 + B·(WR_LOW+WR_HIGH) + D, where B = byte count and D = `delay` (0 for FILL).
  - `req_ready` is high the cycle after `done`.
- Back-to-back requests: a new request can be accepted on the edge ending the first `req_ready` cycle. `csx` is high for at least 2 cycles between transactions.
- `req_valid` while busy is not accepted and not queued.

## Configuration
- `T04_LCD_DELAY_EN`
  - Defined: DELAY state and DLY_W counter are present, behaving as above.
  - Undefined: `delay` is ignored, the DELAY state is not built, and CMD always goes from the final HIGH phase → END. The port remains for pin compatibility.

## Test plan
- Reset mid-FILL: drop `nrst` during a pixel byte → outputs immediately `csx`=`wrx`=`dcx`=1, `data`=0. After release, CMD 0x29 completes normally.
- CMD 0x3A, `nparams`=1, `params`=0x55000000, WR 1/1:
  - Bytes 0x3A (`dcx`=0) then 0x55 (`dcx`=1).
  - `done` 6 cycles after acceptance.
  - Exactly 2 `wrx` rising edges.
- CMD 0x11, `nparams`=0, `delay`=100, macro defined → `done` at acceptance+104. With the macro undefined → `done` at acceptance+4.
- FILL `x_win`=0x000A0013, `y_win`=0x00050005, `color`=0xF800, `count`=10, WR 2/1:
  - Byte stream 2A,00,0A,00,13,2B,00,05,00,05,2C, then 10× (F8,00).
  - 31 strobes.
  - `done` at acceptance+95.
- FILL `count`=0 → 11 bytes, last byte 0x2C, then `done`.
- `nparams`=7 → clamped to 4 bytes. Reserved `op`=11 → `csx` never falls, `done` at acceptance+1.
